// File: rtl/uart_card_frame_rx_if.sv
// RX FIFO read port: show-ahead head byte, empty flag and pop strobe.
// The FIFO side is the master; the frame parser is the slave.
interface uart_card_frame_rx_if;
    logic [7:0] read_data;
    logic       rx_empty;
    logic       rd_uart;

    modport master (output read_data, output rx_empty, input rd_uart);
    modport slave  (input read_data, input rx_empty, output rd_uart);
endinterface

// File: rtl/uart_card_frame_rx.sv
// Card-state frame parser: SOF, TYPE, COUNT, cards, CHK (XOR) read from the
// RX FIFO, committed atomically to the game logic or dropped and counted.
module uart_card_frame_rx #(
    parameter int         MAX_CARDS      = 8,
    parameter int         TIMEOUT_CYCLES = 650000,
    parameter logic [7:0] SOF_BYTE       = 8'hA5
) (
    input  logic                     clk,
    input  logic                     rst,
    uart_card_frame_rx_if.slave      fifo,
    output logic [6*MAX_CARDS-1:0]   cards_out,
    output logic [3:0]               card_count,
    output logic                     frame_deal,
    output logic                     frame_dealer_finished,
    output logic                     frame_error,
    output logic [7:0]               err_count,
    output logic                     busy
);
    localparam int             TW          = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]  TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]     MAXC        = 8'(MAX_CARDS);
    localparam logic [7:0]     TYPE_DEAL   = 8'h01;
    localparam logic [7:0]     TYPE_FINISH = 8'h02;

    typedef enum logic [2:0] {
        S_IDLE, S_TYPE, S_COUNT, S_CARDS, S_CHECK, S_COMMIT
    } state_t;

    function automatic logic card_ok(input logic [7:0] b);
        return (b[7:6] == 2'b00) && (b[3:0] != 4'd0) && (b[3:0] <= 4'd13);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t                state_q, state_d;
    logic [7:0]            chk_q, chk_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [3:0]            idx_q, idx_d;
    logic                  is_deal_q, is_deal_d;
    logic [5:0]            shadow_q [MAX_CARDS];
    logic [5:0]            shadow_d [MAX_CARDS];
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [6*MAX_CARDS-1:0] cards_q, cards_d;
    logic [3:0]            card_count_q, card_count_d;
    logic                  deal_q, deal_d;
    logic                  fin_q, fin_d;
    logic                  err_q, err_d;
    logic [7:0]            err_count_q, err_count_d;
    logic                  busy_q, busy_d;

    logic                  pop_s;
    logic                  in_frame_s;
    logic                  err_s;
    logic                  commit_s;
    logic [7:0]            byte_s;

    // Pop whenever a byte is present, except during the single commit cycle.
    assign pop_s      = !rst && !fifo.rx_empty && (state_q != S_COMMIT);
    assign fifo.rd_uart = pop_s;
    assign byte_s     = fifo.read_data;
    assign in_frame_s = (state_q == S_TYPE) || (state_q == S_COUNT) ||
                        (state_q == S_CARDS) || (state_q == S_CHECK);

    // Next-state, datapath and output decode for the frame parser.
    always_comb begin
        state_d      = state_q;
        chk_d        = chk_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        is_deal_d    = is_deal_q;
        shadow_d     = shadow_q;
        tmo_d        = tmo_q;
        cards_d      = cards_q;
        card_count_d = card_count_q;
        err_count_d  = err_count_q;
        deal_d       = 1'b0;
        fin_d        = 1'b0;
        err_d        = 1'b0;
        err_s        = 1'b0;
        commit_s     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pop_s && (byte_s == SOF_BYTE)) begin
                    state_d = S_TYPE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_TYPE: begin
                if (pop_s) begin
                    if ((byte_s == TYPE_DEAL) || (byte_s == TYPE_FINISH)) begin
                        chk_d     = byte_s;
                        is_deal_d = (byte_s == TYPE_DEAL);
                        state_d   = S_COUNT;
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    state_d = S_TYPE;
                end
            end
            S_COUNT: begin
                if (pop_s) begin
                    if (byte_s <= MAXC) begin
                        cnt_d   = byte_s[3:0];
                        chk_d   = chk_q ^ byte_s;
                        idx_d   = 4'd0;
                        state_d = (byte_s == 8'd0) ? S_CHECK : S_CARDS;
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    state_d = S_COUNT;
                end
            end
            S_CARDS: begin
                if (pop_s) begin
                    if (card_ok(byte_s)) begin
                        for (int i = 0; i < MAX_CARDS; i++) begin
                            if (idx_q == 4'(i)) begin
                                shadow_d[i] = byte_s[5:0];
                            end else begin
                                shadow_d[i] = shadow_q[i];
                            end
                        end
                        chk_d   = chk_q ^ byte_s;
                        idx_d   = idx_q + 4'd1;
                        state_d = (idx_q == (cnt_q - 4'd1)) ? S_CHECK : S_CARDS;
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    state_d = S_CARDS;
                end
            end
            S_CHECK: begin
                if (pop_s) begin
                    if (byte_s == chk_q) begin
                        commit_s = 1'b1;
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    state_d = S_CHECK;
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Idle-gap watchdog: only runs while a frame is open.
        if (in_frame_s) begin
            if (pop_s) begin
                tmo_d = {TW{1'b0}};
            end else if (tmo_q == TMO_LAST) begin
                err_s = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end else begin
            tmo_d = {TW{1'b0}};
        end

        // Outputs are updated on the edge that accepts CHK, so the event
        // pulse and the new cards appear together in the COMMIT cycle.
        if (err_s) begin
            state_d     = S_IDLE;
            err_d       = 1'b1;
            err_count_d = sat_inc(err_count_q);
        end else if (commit_s) begin
            state_d = S_COMMIT;
            for (int i = 0; i < MAX_CARDS; i++) begin
                cards_d[6*i +: 6] = (4'(i) < cnt_q) ? shadow_q[i] : 6'd0;
            end
            card_count_d = cnt_q;
            deal_d       = is_deal_q;
            fin_d        = !is_deal_q;
        end else begin
            err_d = 1'b0;
        end

        busy_d = (state_d == S_TYPE) || (state_d == S_COUNT) ||
                 (state_d == S_CARDS) || (state_d == S_CHECK);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            chk_q        <= 8'd0;
            cnt_q        <= 4'd0;
            idx_q        <= 4'd0;
            is_deal_q    <= 1'b0;
            shadow_q     <= '{default: 6'd0};
            tmo_q        <= {TW{1'b0}};
            cards_q      <= {(6*MAX_CARDS){1'b0}};
            card_count_q <= 4'd0;
            deal_q       <= 1'b0;
            fin_q        <= 1'b0;
            err_q        <= 1'b0;
            err_count_q  <= 8'd0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            chk_q        <= chk_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            is_deal_q    <= is_deal_d;
            shadow_q     <= shadow_d;
            tmo_q        <= tmo_d;
            cards_q      <= cards_d;
            card_count_q <= card_count_d;
            deal_q       <= deal_d;
            fin_q        <= fin_d;
            err_q        <= err_d;
            err_count_q  <= err_count_d;
            busy_q       <= busy_d;
        end
    end

    assign cards_out             = cards_q;
    assign card_count            = card_count_q;
    assign frame_deal            = deal_q;
    assign frame_dealer_finished = fin_q;
    assign frame_error           = err_q;
    assign err_count             = err_count_q;
    assign busy                  = busy_q;
endmodule

// File: doc/uart_card_frame_rx.md
Name: uart_card_frame_rx

Overview:
- Receive-side parser for the framed card-state link between two boards. The peer transmitter serialises hand snapshots as checksummed frames, and this block reads them back byte by byte from the uart RX FIFO.
- It validates each frame, stages the card codes, and commits them atomically to the game logic.
- Event pulses (deal / dealer finished) feed blackjack_FSM. Malformed frames are dropped and counted.

Parameters:
- MAX_CARDS, 8: maximum cards per frame; size of the card buffer.
- TIMEOUT_CYCLES, 650000: idle cycles allowed mid-frame before abort (10 ms at 65 MHz).
- SOF_BYTE, 8'hA5: start-of-frame marker.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- read_data  in  8  RX FIFO head byte (show-ahead, valid while rx_empty=0).
- rx_empty  in  1  RX FIFO empty.
- rd_uart  out  1  pop strobe; the byte on read_data is consumed in any cycle rd_uart=1.
- cards_out  out  6*MAX_CARDS  committed card codes; card i at [6i+5:6i], {suit[1:0],rank[3:0]}.
- card_count  out  4  number of valid committed cards.
- frame_deal  out  1  one-cycle pulse: valid DEAL frame committed.
- frame_dealer_finished  out  1  one-cycle pulse: valid DEALER_FINISHED frame committed.
- frame_error  out  1  one-cycle pulse: frame rejected.
- err_count  out  8  saturating rejected-frame counter.
- busy  out  1  high from SOF accepted until commit/abort.

Behaviour:
- Frame format: SOF, TYPE, COUNT, COUNT card bytes, CHK.
- TYPE values: 8'h01 = DEAL, 8'h02 = DEALER_FINISHED. Any other value is an error.
- COUNT range is 0..MAX_CARDS; greater is an error.
- Card byte layout: [7:6] must be 0, [5:4] suit, [3:0] rank 1..13. Rank 0 or rank >13 or nonzero [7:6] is an error.
- CHK equals the XOR of TYPE, COUNT and all card bytes. SOF is excluded.
- rd_uart = !rx_empty && state != COMMIT. This gives at most one byte per cycle and needs no extra wait cycle.
- FSM states:
  - IDLE: bytes other than SOF are discarded silently with no error. SOF goes to TYPE.
  - TYPE: a valid type is latched into the running checksum, go to COUNT. Otherwise error.
  - COUNT: range-check. COUNT=0 goes to CHECK; otherwise go to CARDS with idx=0.
  - CARDS: validate each byte and write it into the shadow buffer at idx, idx++. After the COUNT-th byte, go to CHECK.
  - CHECK: compare the received byte with the running XOR. Match goes to COMMIT; mismatch is an error.
  - COMMIT, one cycle:
    - Copy the shadow buffer to cards_out; unused slots become 0.
    - Set card_count=COUNT.
    - Pulse frame_deal or frame_dealer_finished.
    - Return to IDLE.
- Error path, taken from any state on error:
  - frame_error pulses in the cycle after the offending byte is accepted.
  - err_count increments, saturating at 255.
  - Next state is IDLE. cards_out and card_count are untouched, and the shadow buffer is discarded.
- SOF inside a frame is treated as data only: a valid TYPE/COUNT/card value, or checksum input. There is no resynchronisation mid-frame.
- Latency: the event pulse is high exactly one cycle after the cycle in which CHK is popped.
- Timeout:
  - A counter runs in every state except IDLE and COMMIT, and clears on each popped byte.
  - When it reaches TIMEOUT_CYCLES-1 without a pop, the frame aborts through the error path.
- Back-to-back frames: a SOF present during COMMIT waits one cycle, then is popped in IDLE. No bytes are lost.
- Reset (also when asserted mid-frame):
  - state=IDLE.
  - All outputs 0: cards_out, card_count, pulses, err_count, busy, rd_uart.
  - Shadow buffer, checksum and timeout counter cleared. A partial frame is abandoned; its remaining bytes are discarded as non-SOF junk.
- At most one of frame_deal, frame_dealer_finished and frame_error is high in any cycle.

Test Plan:
1. DEAL frame A5 01 02 1A 25 CHK=3C, FIFO non-empty continuously → rd_uart high 5 consecutive cycles; next cycle frame_deal=1; card_count=2; cards_out[5:0]=6'h1A, [11:6]=6'h25; slots 2..7 = 0.
2. Same frame with CHK=3D → frame_error pulse, err_count=1, cards_out/card_count keep previous values, no frame_deal.
3. Junk 00 FF 13 then A5 02 00 02 → no error for the junk; frame_dealer_finished pulses; card_count=0.
4. A5 01 09 (COUNT>MAX_CARDS) → error after the COUNT byte. Also A5 01 01 0E (rank 14) → error after the card byte.
5. A5 01 followed by a TIMEOUT_CYCLES stall → frame_error, busy=0. A full valid frame afterwards commits correctly.
6. rst for 1 cycle mid-CARDS, then a fresh valid frame → all outputs 0 after reset, the new frame commits, err_count=0. Also: 260 bad frames → err_count saturates at 255.
